lcd_frame_composer: RTL and testbench



---
 rtl/lcd_fmt_pkg.sv | 38 +++
 rtl/lcd_blink_timer.sv | 38 +++
 rtl/lcd_frame_composer.sv | 171 +++++++++++++++++
 tb/tb_lcd_frame_composer.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/lcd_fmt_pkg.sv
// lcd_fmt_pkg: shared definitions for the LCD frame composer.
//   - ASCII constants used when building display lines
//   - weekday name ROM (index 0 = invalid -> "EEE", 1..7 = Mon..Sun)
//   - clk_mode / edit_field enums
//   - bcd2ascii: one BCD nibble to one display character
package lcd_fmt_pkg;

    localparam logic [7:0] ASCII_SP    = 8'h20;
    localparam logic [7:0] ASCII_COLON = 8'h3A;
    localparam logic [7:0] ASCII_DASH  = 8'h2D;
    localparam logic [7:0] ASCII_COMMA = 8'h2C;
    localparam logic [7:0] ASCII_QMARK = 8'h3F;
    localparam logic [7:0] ASCII_STAR  = 8'h2A;

    typedef enum logic [1:0] {
        MODE_NORMAL    = 2'd0,
        MODE_SET_TIME  = 2'd1,
        MODE_SET_DATE  = 2'd2,
        MODE_SET_ALARM = 2'd3
    } clk_mode_e;

    typedef enum logic [1:0] {
        FLD_HOUR_DAY  = 2'd0,
        FLD_MIN_MONTH = 2'd1,
        FLD_SEC_YEAR  = 2'd2,
        FLD_NONE      = 2'd3
    } edit_field_e;

    // Ascending ranges: leftmost literal is entry 0, first letter is char 0.
    localparam logic [0:7][0:2][7:0] WDAY_ROM = {
        "EEE", "Mon", "Tue", "Wed", "Thu", "Fri", "Sat", "Sun"
    };

    function automatic logic [7:0] bcd2ascii(input logic [3:0] d);
        return (d > 4'd9) ? ASCII_QMARK : (8'h30 | {4'h0, d});
    endfunction

endpackage

// File: rtl/lcd_blink_timer.sv
// lcd_blink_timer: free-running blink phase generator.
//   mclk    : clock
//   rst_n   : async active-low reset (counter 0, phase 0)
//   restart : sync clear of counter and phase (field becomes visible)
//   phase   : toggles each time the counter wraps after HALF_PERIOD cycles
module lcd_blink_timer #(
    parameter int HALF_PERIOD = 1
) (
    input  logic mclk,
    input  logic rst_n,
    input  logic restart,
    output logic phase
);

    localparam int CW = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;
    localparam logic [CW-1:0] LAST = CW'(HALF_PERIOD - 1);

    logic [CW-1:0] r_cnt;
    logic          r_phase;

    always_ff @(posedge mclk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt   <= '0;
            r_phase <= 1'b0;
        end else if (restart) begin
            r_cnt   <= '0;
            r_phase <= 1'b0;
        end else if (r_cnt == LAST) begin
            r_cnt   <= '0;
            r_phase <= ~r_phase;
        end else begin
            r_cnt   <= r_cnt + 1'b1;
        end
    end

    assign phase = r_phase;

endmodule

// File: rtl/lcd_frame_composer.sv
// lcd_frame_composer: renders clock/date/weekday BCD into two ASCII lines
// and hands them to the LCD controller as whole frames.
//   mclk, rst_n        : clock, async active-low reset
//   clk_mode           : 0 normal, 1 set time, 2 set date, 3 set alarm
//   edit_field         : field being edited (3 = none)
//   bcd_time, ampm,
//   mode_12h           : time digits (h,m,s tens/ones from LSB), PM flag, 12h suffix
//   weekday, date      : weekday 1..7, date digits (d,mo,y tens/ones from LSB)
//   alarm_en           : shows "ALM" on line A
//   line_a, line_b     : held frame, character 0 in bits [7:0]
//   frame_valid/ready  : held frame is new / consumer takes it
module lcd_frame_composer
    import lcd_fmt_pkg::*;
#(
    parameter int M_FREQ       = 1,
    parameter int LINE_CHARS   = 16,
    parameter int SHOW_SECONDS = 1
) (
    input  logic                    mclk,
    input  logic                    rst_n,
    input  logic [1:0]              clk_mode,
    input  logic [1:0]              edit_field,
    input  logic [23:0]             bcd_time,
    input  logic                    ampm,
    input  logic                    mode_12h,
    input  logic [2:0]              weekday,
    input  logic [23:0]             date,
    input  logic                    alarm_en,
    output logic [8*LINE_CHARS-1:0] line_a,
    output logic [8*LINE_CHARS-1:0] line_b,
    output logic                    frame_valid,
    input  logic                    frame_ready
);

    localparam int HALF_PERIOD = (M_FREQ / 2 < 1) ? 1 : M_FREQ / 2;
    localparam int AP_COL      = (SHOW_SECONDS != 0) ? 9 : 6;

    typedef enum logic {ST_IDLE, ST_PENDING} state_e;

    state_e                       r_state, w_next_state;
    logic                         w_load;
    logic [LINE_CHARS-1:0][7:0]   w_a, w_b, r_line_a, r_line_b;
    logic [1:0]                   r_prev_mode, r_prev_field;
    logic                         w_restart, w_phase, w_blank;
    clk_mode_e                    w_mode;
    edit_field_e                  w_field;

    assign w_mode  = clk_mode_e'(clk_mode);
    assign w_field = edit_field_e'(edit_field);

    // Any change of mode/field restarts the blink so the new field shows at once.
    always_ff @(posedge mclk or negedge rst_n) begin
        if (!rst_n) begin
            r_prev_mode  <= 2'd0;
            r_prev_field <= 2'd3;
        end else begin
            r_prev_mode  <= clk_mode;
            r_prev_field <= edit_field;
        end
    end

    assign w_restart = (clk_mode != r_prev_mode) || (edit_field != r_prev_field);

    lcd_blink_timer #(.HALF_PERIOD(HALF_PERIOD)) u_blink (
        .mclk    (mclk),
        .rst_n   (rst_n),
        .restart (w_restart),
        .phase   (w_phase)
    );

    // Mask the phase during the restart cycle so the stale phase never leaks out.
    assign w_blank = w_phase && !w_restart && (w_mode != MODE_NORMAL) && (w_field != FLD_NONE);

    always_comb begin
        w_a = {LINE_CHARS{ASCII_SP}};
        w_b = {LINE_CHARS{ASCII_SP}};

        for (int i = 0; i < 3; i++) w_a[i] = WDAY_ROM[weekday][i];
        w_a[3]  = ASCII_COMMA;
        w_a[4]  = bcd2ascii(date[3:0]);
        w_a[5]  = bcd2ascii(date[7:4]);
        w_a[6]  = ASCII_DASH;
        w_a[7]  = bcd2ascii(date[11:8]);
        w_a[8]  = bcd2ascii(date[15:12]);
        w_a[9]  = ASCII_DASH;
        w_a[10] = bcd2ascii(date[19:16]);
        w_a[11] = bcd2ascii(date[23:20]);
        if (alarm_en) begin
            w_a[12] = "A";
            w_a[13] = "L";
            w_a[14] = "M";
        end
        if (w_mode == MODE_SET_ALARM) w_a[15] = ASCII_STAR;

        w_b[0] = bcd2ascii(bcd_time[3:0]);
        w_b[1] = bcd2ascii(bcd_time[7:4]);
        w_b[2] = ASCII_COLON;
        w_b[3] = bcd2ascii(bcd_time[11:8]);
        w_b[4] = bcd2ascii(bcd_time[15:12]);
        if (SHOW_SECONDS != 0) begin
            w_b[5] = ASCII_COLON;
            w_b[6] = bcd2ascii(bcd_time[19:16]);
            w_b[7] = bcd2ascii(bcd_time[23:20]);
        end
        if (mode_12h) begin
            w_b[AP_COL]     = ampm ? "P" : "A";
            w_b[AP_COL + 1] = "M";
        end

        if (w_blank) begin
            if (w_mode == MODE_SET_DATE) begin
                case (w_field)
                    FLD_HOUR_DAY:  begin w_a[4]  = ASCII_SP; w_a[5]  = ASCII_SP; end
                    FLD_MIN_MONTH: begin w_a[7]  = ASCII_SP; w_a[8]  = ASCII_SP; end
                    FLD_SEC_YEAR:  begin w_a[10] = ASCII_SP; w_a[11] = ASCII_SP; end
                    default: ;
                endcase
            end else begin
                case (w_field)
                    FLD_HOUR_DAY:  begin w_b[0] = ASCII_SP; w_b[1] = ASCII_SP; end
                    FLD_MIN_MONTH: begin w_b[3] = ASCII_SP; w_b[4] = ASCII_SP; end
                    FLD_SEC_YEAR: begin
                        if (SHOW_SECONDS != 0) begin
                            w_b[6] = ASCII_SP;
                            w_b[7] = ASCII_SP;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge mclk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_next_state;
    end

    // Capture only from idle; the accept edge never captures, giving a 1-cycle bubble.
    always_comb begin
        w_next_state = r_state;
        w_load       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if ({w_a, w_b} != {r_line_a, r_line_b}) begin
                    w_load       = 1'b1;
                    w_next_state = ST_PENDING;
                end
            end
            ST_PENDING: begin
                if (frame_ready) w_next_state = ST_IDLE;
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge mclk or negedge rst_n) begin
        if (!rst_n) begin
            r_line_a <= {LINE_CHARS{ASCII_SP}};
            r_line_b <= {LINE_CHARS{ASCII_SP}};
        end else if (w_load) begin
            r_line_a <= w_a;
            r_line_b <= w_b;
        end
    end

    assign line_a      = r_line_a;
    assign line_b      = r_line_b;
    assign frame_valid = (r_state == ST_PENDING);

endmodule

// File: tb/tb_lcd_frame_composer.sv
module tb_lcd_frame_composer;

    logic         mclk = 1'b0;
    logic         rst_n = 1'b0;
    logic [1:0]   clk_mode;
    logic [1:0]   edit_field;
    logic [23:0]  bcd_time;
    logic         ampm;
    logic         mode_12h;
    logic [2:0]   weekday;
    logic [23:0]  date;
    logic         alarm_en;
    logic [127:0] line_a;
    logic [127:0] line_b;
    logic         frame_valid;
    logic         frame_ready;

    int checks = 0;
    int errors = 0;

    localparam logic [127:0] SPACES = {16{8'h20}};

    lcd_frame_composer #(.M_FREQ(4), .LINE_CHARS(16), .SHOW_SECONDS(1)) dut (
        .mclk        (mclk),
        .rst_n       (rst_n),
        .clk_mode    (clk_mode),
        .edit_field  (edit_field),
        .bcd_time    (bcd_time),
        .ampm        (ampm),
        .mode_12h    (mode_12h),
        .weekday     (weekday),
        .date        (date),
        .alarm_en    (alarm_en),
        .line_a      (line_a),
        .line_b      (line_b),
        .frame_valid (frame_valid),
        .frame_ready (frame_ready)
    );

    always #5 mclk = ~mclk;

    // Column 0 lands in bits [7:0]; short strings are space padded.
    function automatic logic [127:0] s2l(input string s);
        logic [127:0] r;
        for (int i = 0; i < 16; i++) r[i*8 +: 8] = (i < s.len()) ? s[i] : 8'h20;
        return r;
    endfunction

    task automatic test_reset();
        clk_mode = 2'd0; edit_field = 2'd3; ampm = 1'b0; mode_12h = 1'b0;
        alarm_en = 1'b0; frame_ready = 1'b1; weekday = 3'd2;
        bcd_time = 24'h654321;  // 12:34:56
        date     = 24'h523070;  // 07-03-25
        rst_n = 1'b0;
        @(negedge mclk);
        checks++; if (line_a !== SPACES) begin errors++; $display("FAIL reset_line_a got %h want %h", line_a, SPACES); end
        checks++; if (line_b !== SPACES) begin errors++; $display("FAIL reset_line_b got %h want %h", line_b, SPACES); end
        checks++; if (frame_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", frame_valid); end
        rst_n = 1'b1;
        @(negedge mclk);
        checks++; if (frame_valid !== 1'b1) begin errors++; $display("FAIL first_valid got %b want 1", frame_valid); end
        checks++; if (line_a !== s2l("Tue,07-03-25")) begin errors++; $display("FAIL first_line_a got %h want %h", line_a, s2l("Tue,07-03-25")); end
        checks++; if (line_b !== s2l("12:34:56")) begin errors++; $display("FAIL first_line_b got %h want %h", line_b, s2l("12:34:56")); end
        for (int k = 0; k < 3; k++) begin
            @(negedge mclk);
            checks++; if (frame_valid !== 1'b0) begin errors++; $display("FAIL static_valid[%0d] got %b want 0", k, frame_valid); end
        end
    endtask

    task automatic test_pending();
        frame_ready = 1'b0;
        weekday = 3'd3;
        @(negedge mclk);
        checks++; if (frame_valid !== 1'b1) begin errors++; $display("FAIL pend_valid got %b want 1", frame_valid); end
        checks++; if (line_a !== s2l("Wed,07-03-25")) begin errors++; $display("FAIL pend_line_a got %h want %h", line_a, s2l("Wed,07-03-25")); end
        bcd_time = 24'h754321;  // 12:34:57
        for (int k = 0; k < 3; k++) begin
            @(negedge mclk);
            checks++; if (frame_valid !== 1'b1 || line_b !== s2l("12:34:56")) begin
                errors++; $display("FAIL pend_frozen[%0d] got v=%b %h want v=1 %h", k, frame_valid, line_b, s2l("12:34:56"));
            end
        end
        frame_ready = 1'b1;
        @(negedge mclk);
        checks++; if (frame_valid !== 1'b0 || line_b !== s2l("12:34:56")) begin
            errors++; $display("FAIL accept_bubble got v=%b %h want v=0 %h", frame_valid, line_b, s2l("12:34:56"));
        end
        frame_ready = 1'b0;
        @(negedge mclk);
        checks++; if (frame_valid !== 1'b1 || line_b !== s2l("12:34:57")) begin
            errors++; $display("FAIL recapture got v=%b %h want v=1 %h", frame_valid, line_b, s2l("12:34:57"));
        end
        frame_ready = 1'b1;
        repeat (3) @(negedge mclk);
    endtask

    task automatic test_blink();
        bit min_vis[8] = '{1, 1, 1, 0, 0, 1, 1, 0};
        bit hr_vis[6]  = '{1, 1, 1, 0, 0, 1};
        logic [15:0] exp;
        clk_mode = 2'd1; edit_field = 2'd1;
        for (int k = 0; k < 8; k++) begin
            @(negedge mclk);
            exp = min_vis[k] ? 16'h3433 : 16'h2020;
            checks++; if (line_b[39:24] !== exp) begin errors++; $display("FAIL blink_min[%0d] got %h want %h", k, line_b[39:24], exp); end
        end
        checks++; if (line_b[23:16] !== 8'h3A) begin errors++; $display("FAIL blink_colon got %h want 3a", line_b[23:16]); end
        edit_field = 2'd0;
        for (int k = 0; k < 6; k++) begin
            @(negedge mclk);
            exp = hr_vis[k] ? 16'h3231 : 16'h2020;
            checks++; if (line_b[15:0] !== exp) begin errors++; $display("FAIL blink_hr[%0d] got %h want %h", k, line_b[15:0], exp); end
            if (k == 1) begin
                checks++; if (line_b[39:24] !== 16'h3433) begin errors++; $display("FAIL blink_min_restored got %h want 3433", line_b[39:24]); end
            end
        end
        clk_mode = 2'd0; edit_field = 2'd3;
        repeat (4) @(negedge mclk);
    endtask

    task automatic test_alarm_mode();
        mode_12h = 1'b1; ampm = 1'b1; alarm_en = 1'b1; clk_mode = 2'd3; edit_field = 2'd3;
        repeat (4) @(negedge mclk);
        checks++; if (line_b[87:72] !== 16'h4D50) begin errors++; $display("FAIL pm_cols got %h want 4d50", line_b[87:72]); end
        checks++; if (line_a !== s2l("Wed,07-03-25ALM*")) begin errors++; $display("FAIL alarm_line_a got %h want %h", line_a, s2l("Wed,07-03-25ALM*")); end
        checks++; if (line_b !== s2l("12:34:57 PM")) begin errors++; $display("FAIL alarm_line_b got %h want %h", line_b, s2l("12:34:57 PM")); end
        ampm = 1'b0; clk_mode = 2'd0; alarm_en = 1'b0;
        repeat (4) @(negedge mclk);
        checks++; if (line_b !== s2l("12:34:57 AM")) begin errors++; $display("FAIL am_line_b got %h want %h", line_b, s2l("12:34:57 AM")); end
        checks++; if (line_a !== s2l("Wed,07-03-25")) begin errors++; $display("FAIL noalarm_line_a got %h want %h", line_a, s2l("Wed,07-03-25")); end
        mode_12h = 1'b0;
        repeat (4) @(negedge mclk);
    endtask

    task automatic test_invalid();
        weekday  = 3'd0;
        date     = 24'h52307A;  // day tens = 0xA
        bcd_time = 24'h75432F;  // hour tens = 0xF
        repeat (4) @(negedge mclk);
        checks++; if (line_a !== s2l("EEE,?7-03-25")) begin errors++; $display("FAIL invalid_line_a got %h want %h", line_a, s2l("EEE,?7-03-25")); end
        checks++; if (line_b !== s2l("?2:34:57")) begin errors++; $display("FAIL invalid_line_b got %h want %h", line_b, s2l("?2:34:57")); end
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < 6; k++) begin
            bcd_time[23:20] = 4'(k);
            @(negedge mclk);
            checks++; if (frame_valid !== ((k % 2) == 0)) begin
                errors++; $display("FAIL b2b_valid[%0d] got %b want %b", k, frame_valid, ((k % 2) == 0));
            end
            if ((k % 2) == 0) begin
                checks++; if (line_b[63:56] !== 8'(8'h30 + k)) begin
                    errors++; $display("FAIL b2b_sec[%0d] got %h want %h", k, line_b[63:56], 8'(8'h30 + k));
                end
            end
        end
        repeat (3) @(negedge mclk);
    endtask

    task automatic test_async_reset();
        frame_ready = 1'b0;
        weekday = 3'd5;
        @(negedge mclk);
        checks++; if (frame_valid !== 1'b1) begin errors++; $display("FAIL arst_pre_valid got %b want 1", frame_valid); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (frame_valid !== 1'b0) begin errors++; $display("FAIL arst_valid got %b want 0", frame_valid); end
        checks++; if (line_a !== SPACES || line_b !== SPACES) begin
            errors++; $display("FAIL arst_lines got %h %h want all 20", line_a, line_b);
        end
        @(negedge mclk);
        rst_n = 1'b1; frame_ready = 1'b1;
        @(negedge mclk);
        checks++; if (frame_valid !== 1'b1 || line_a !== s2l("Fri,?7-03-25")) begin
            errors++; $display("FAIL arst_refill got v=%b %h want v=1 %h", frame_valid, line_a, s2l("Fri,?7-03-25"));
        end
    endtask

    initial begin
        test_reset();
        test_pending();
        test_blink();
        test_alarm_mode();
        test_invalid();
        test_back_to_back();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
